// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display datapath.
// Holds the BCD controller state encoding and the decimal range helper.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_ctrl_state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // 10**n - 1 in 64-bit arithmetic. For n >= 20 the true value no longer fits
  // in 64 bits, so the result clamps to all ones, which is still >= any
  // binary input of up to 64 bits.
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    if (n >= 20) begin
      return '1;
    end
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter feeding seven_segment_display.
// Converts one value per request by iterative shift-add-3 and saturates to all 9s.
//
// Handshake: a request is accepted on the rising clock edge where bin_valid and
// bin_ready are both high; bin_in is captured at that edge only. bin_ready is
// high exactly while the controller is in IDLE. bcd_update pulses for one cycle
// when bcd_out/overflow take a new value.
module bcd_display_ctrl
  import display_pkg::*;
#(
  parameter int DECIMAL_NUM = 6,
  parameter int BIN_WIDTH   = 20,
  parameter int BCD_WIDTH   = DECIMAL_NUM * 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [BCD_WIDTH-1:0]  bcd_out,
  output logic                  bcd_update,
  output logic                  overflow,
  output bcd_ctrl_state_t       dbg_state
);

  localparam int          CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int          CMP_W = (BIN_WIDTH > 64) ? BIN_WIDTH : 64;
  localparam logic [63:0] MAX64 = pow10_minus1(DECIMAL_NUM);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

  bcd_ctrl_state_t        r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIN_WIDTH-1:0]   r_shift;
  logic [BCD_WIDTH-1:0]   r_work;
  logic                   r_ovf_pend;
  logic [BCD_WIDTH-1:0]   r_bcd_out;
  logic                   r_bcd_update;
  logic                   r_overflow;

  logic [BCD_WIDTH-1:0]   w_adj;
  logic [CMP_W-1:0]       w_bin_ext;
  logic                   w_ovf;
  logic                   w_accept;

  // Comparing in at least 64 bits makes the check vanish naturally when the
  // display range exceeds what BIN_WIDTH can represent.
  assign w_bin_ext = CMP_W'(bin_in);
  assign w_ovf     = (w_bin_ext > CMP_W'(MAX64));
  assign w_accept  = bin_valid && bin_ready;

  genvar g;
  generate
    for (g = 0; g < DECIMAL_NUM; g++) begin : g_digit
      bcd_add3 u_add3 (
        .i_digit (r_work[4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_work       <= '0;
      r_ovf_pend   <= 1'b0;
      r_bcd_out    <= '0;
      r_bcd_update <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bcd_update <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= bin_in;
            r_work     <= '0;
            r_ovf_pend <= w_ovf;
            r_cnt      <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct digits, then shift {work,shift} left; the top work bit is
          // lost only for inputs that will saturate anyway.
          r_work  <= (w_adj << 1) | BCD_WIDTH'(r_shift[BIN_WIDTH-1]);
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_bcd_out    <= r_ovf_pend ? {DECIMAL_NUM{BCD_NINE}} : r_work;
          r_overflow   <= r_ovf_pend;
          r_bcd_update <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bin_ready  = (r_state == IDLE);
  assign bcd_out    = r_bcd_out;
  assign bcd_update = r_bcd_update;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: directed vectors plus a random sweep,
// with expected results queued at acceptance and checked when bcd_update pulses.
module tb_bcd_display_ctrl;
  import display_pkg::*;

  localparam int DN = 6;
  localparam int BW = 20;
  localparam int CW = DN * 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   bin_in;
  logic            bin_valid;
  logic            bin_ready;
  logic [CW-1:0]   bcd_out;
  logic            bcd_update;
  logic            overflow;
  bcd_ctrl_state_t dbg_state;

  logic [CW:0] exp_q[$];   // {overflow, bcd}
  int upd_cyc_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_abort  = 0;
  int n_upd    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  bcd_display_ctrl #(.DECIMAL_NUM(DN), .BIN_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bin_in     (bin_in),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bcd_out    (bcd_out),
    .bcd_update (bcd_update),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: decimal digits by division, saturate above 999999
  function automatic logic [CW:0] model(input logic [BW-1:0] v);
    logic [CW-1:0] b;
    int x;
    b = '0;
    if (v > 20'd999999) return {1'b1, 24'h999999};
    x = int'(v);
    for (int i = 0; i < DN; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, b};
  endfunction

  // driver: present a request, wait for acceptance, queue its expectation
  task automatic send(input logic [BW-1:0] v, input logic [CW:0] exp, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    bin_in    = v;
    bin_valid = 1'b1;
    while (!bin_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(exp);
      n_acc++;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    if (!hold) bin_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bcd_update) begin
      n_upd++;
      upd_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        logic [CW:0] e;
        e = exp_q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e[CW-1:0]));
        chk("overflow", 32'(overflow), 32'(e[CW]));
      end
    end
  end

  initial begin
    int gap;
    rst       = 1'b1;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state and idle without requests
    chk("rst_bcd_out", 32'(bcd_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(bin_ready), 32'd1);
    chk("rst_update", 32'(bcd_update), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (10) @(negedge clk);
    chk("idle_no_update", 32'(n_upd), 32'd0);

    // latency for 123456
    send(20'd123456, {1'b0, 24'h123456}, 1'b0);
    for (int k = 1; k <= BW + 1; k++) begin
      @(posedge clk);
      #1;
      if (k <= BW) begin
        chk("busy_ready_low", 32'(bin_ready), 32'd0);
        chk("busy_no_update", 32'(bcd_update), 32'd0);
      end else begin
        chk("lat_update", 32'(bcd_update), 32'd1);
        chk("lat_ready", 32'(bin_ready), 32'd1);
        chk("lat_bcd_out", 32'(bcd_out), 32'h123456);
      end
    end
    drain();

    // boundaries
    send(20'd999999, {1'b0, 24'h999999}, 1'b0);
    send(20'd1000000, {1'b1, 24'h999999}, 1'b0);
    send(20'd0, {1'b0, 24'h000000}, 1'b0);
    send(20'd1048575, {1'b1, 24'h999999}, 1'b0);
    send(20'd100000, {1'b0, 24'h100000}, 1'b0);
    drain();

    // back-to-back with bin_valid held and bin_in changed mid-conversion
    upd_cyc_q.delete();
    send(20'd7, {1'b0, 24'h000007}, 1'b1);
    send(20'd42, {1'b0, 24'h000042}, 1'b0);
    drain();
    if (upd_cyc_q.size() == 2) begin
      gap = upd_cyc_q[1] - upd_cyc_q[0];
      chk("b2b_gap", 32'(gap), 32'd22);
    end else begin
      chk("b2b_update_count", 32'(upd_cyc_q.size()), 32'd2);
    end

    // reset during conversion aborts it
    send(20'd555555, {1'b0, 24'h555555}, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    n_abort++;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bcd_out", 32'(bcd_out), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_ready", 32'(bin_ready), 32'd1);
    repeat (30) @(negedge clk);
    send(20'd31, {1'b0, 24'h000031}, 1'b0);
    drain();

    // random sweep
    for (int i = 0; i < 2000; i++) begin
      logic [BW-1:0] v;
      v = BW'($urandom_range(0, (1 << BW) - 1));
      send(v, model(v), ($urandom_range(0, 1) == 1));
    end
    @(negedge clk);
    bin_valid = 1'b0;
    drain();
    chk("update_count", 32'(n_upd), 32'(n_acc - n_abort));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
